target_packer: RTL and testbench

TARGET_PACKER -- requirements
Module: target_packer

---
 rtl/sw_pkg.sv | 21 ++
 rtl/target_packer.sv | 116 +++++++++++
 tb/tb_target_packer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// sw_pkg: sizing defaults and the packer state encoding.
// The target feeder imports the same package, so these values must stay in step with it.
package sw_pkg;

  localparam int SW_TARGET_LENGTH = 128;
  localparam int SW_LEN_WIDTH     = 12;
  localparam int SW_ID_WIDTH      = 48;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PEND    = 2'd2,
    ST_LOAD    = 2'd3
  } pk_state_t;

  // Number of bases carried by a beat: 4, except on a last beat with a nonzero count.
  function automatic logic [2:0] beat_bases(input logic last, input logic [1:0] nb);
    return (last && nb != 2'd0) ? {1'b0, nb} : 3'd4;
  endfunction

endpackage

// File: rtl/target_packer.sv
// target_packer: packs a stream of 2-bit bases into one {ID, LENGTH, TARGET} word.
// The word is handed to the target feeder with a one-cycle ld strobe.
// Optional macro PACKER_ERR_EN adds a sticky err flag. It is set by a sequence that
// overruns TARGET_LENGTH, by a restart in COLLECT, or by a stray beat in IDLE.
module target_packer
  import sw_pkg::*;
#(
  parameter int TARGET_LENGTH = SW_TARGET_LENGTH,
  parameter int LEN_WIDTH     = SW_LEN_WIDTH,
  parameter int ID_WIDTH      = SW_ID_WIDTH,
  parameter int OUT_WIDTH     = ID_WIDTH + LEN_WIDTH + 2*TARGET_LENGTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_first,
  input  logic                 s_last,
  input  logic [1:0]           s_nbases,
  input  logic [ID_WIDTH-1:0]  s_id,
  input  logic                 full,
  output logic                 ld,
  output logic [OUT_WIDTH-1:0] feed_out,
  output logic                 err
);

  localparam int TGT_W = 2*TARGET_LENGTH;
  localparam logic [LEN_WIDTH:0] CNT_MAX = {1'b0, {LEN_WIDTH{1'b1}}};
  localparam logic [LEN_WIDTH-1:0] LEN_CAP = LEN_WIDTH'(TARGET_LENGTH);

  pk_state_t            r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]  r_id, w_id_nxt;
  logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [TGT_W-1:0]     r_tgt, w_tgt_nxt;
  logic                 r_ld;

  logic                 w_acc, w_start, w_append;
  logic [2:0]           w_nb;
  logic [LEN_WIDTH-1:0] w_cnt_base, w_cnt_sat, w_len;
  logic [LEN_WIDTH:0]   w_cnt_sum;

  assign s_ready  = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign w_acc    = s_valid && s_ready;
  // s_first always (re)starts a sequence; non-first beats only count while collecting.
  assign w_start  = w_acc && s_first;
  assign w_append = w_acc && !s_first && (r_state == ST_COLLECT);
  assign w_nb     = beat_bases(s_last, s_nbases);

  assign w_cnt_base = w_start ? '0 : r_cnt;
  assign w_cnt_sum  = {1'b0, w_cnt_base} + (LEN_WIDTH+1)'(w_nb);
  assign w_cnt_sat  = (w_cnt_sum > CNT_MAX) ? CNT_MAX[LEN_WIDTH-1:0] : w_cnt_sum[LEN_WIDTH-1:0];
  assign w_len      = (r_cnt > LEN_CAP) ? LEN_CAP : r_cnt;

  assign feed_out = {r_id, w_len, r_tgt};
  assign ld       = r_ld;

  // Next-state and word update: place beat bases at the running count, drop overflow.
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt;
    if (w_start || w_append) begin
      if (w_start) begin
        w_id_nxt  = s_id;
        w_tgt_nxt = '0;
      end
      for (int j = 0; j < 4; j++) begin
        if (j < int'(w_nb) && int'(w_cnt_base) + j < TARGET_LENGTH)
          w_tgt_nxt = w_tgt_nxt | (TGT_W'(s_data[2*j +: 2]) << (2*(int'(w_cnt_base) + j)));
      end
      w_cnt_nxt   = w_cnt_sat;
      w_state_nxt = s_last ? ST_PEND : ST_COLLECT;
    end
    case (r_state)
      ST_PEND: if (!full) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_IDLE;
      default: ;
    endcase
  end

  // State, word registers and the registered load strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_ld    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tgt   <= w_tgt_nxt;
      r_ld    <= (w_state_nxt == ST_LOAD);
    end
  end

`ifdef PACKER_ERR_EN
  logic r_err;
  logic w_err_evt;
  assign w_err_evt = (w_start && r_state == ST_COLLECT) ||
                     (w_acc && !s_first && r_state == ST_IDLE) ||
                     ((w_start || w_append) && s_last && w_cnt_sat > LEN_CAP);
  // Sticky protocol/overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= r_err | w_err_evt;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_target_packer.sv
// tb_target_packer: directed table, hand-written corner sequences and random sequences.
// The reference model keeps the bases of each sequence in a queue.
module tb_target_packer;

  localparam int TL = 128, LW = 12, IW = 48;
  localparam int OW = IW + LW + 2*TL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0, s_first = 1'b0, s_last = 1'b0, full = 1'b0;
  logic [7:0]    s_data = '0;
  logic [1:0]    s_nbases = '0;
  logic [IW-1:0] s_id = '0;
  logic          s_ready, ld, err;
  logic [OW-1:0] feed_out;

  target_packer #(.TARGET_LENGTH(TL), .LEN_WIDTH(LW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_first(s_first), .s_last(s_last), .s_nbases(s_nbases), .s_id(s_id),
    .full(full), .ld(ld), .feed_out(feed_out), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state
  logic [1:0]    mq[$];
  logic          in_seq = 1'b0;
  logic [IW-1:0] m_id = '0;
  logic          exp_err = 1'b0;
  logic [OW-1:0] last_word;

  typedef struct {
    logic [IW-1:0]   id;
    int              nbeats;
    logic [2:0][7:0] d;
    logic [1:0]      nb;
    logic [LW-1:0]   len;
    logic [23:0]     tgt;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] model_word();
    logic [OW-1:0] w = '0;
    int n = (mq.size() > TL) ? TL : mq.size();
    for (int k = 0; k < n; k++) w[2*k +: 2] = mq[k];
    w[2*TL +: LW] = LW'(n);
    w[OW-1 -: IW] = m_id;
    return w;
  endfunction

  function automatic logic [OW-1:0] mk_word(input logic [IW-1:0] id, input logic [LW-1:0] len,
                                             input logic [2*TL-1:0] tgt);
    return {id, len, tgt};
  endfunction

  // Drive one beat for a cycle and update the model with the same beat.
  task automatic send(input logic [7:0] d, input logic f, input logic l, input logic [1:0] nb,
                      input logic [IW-1:0] id);
    int n;
    if (f) begin
      if (in_seq) exp_err = 1'b1;
      mq.delete();
      in_seq = 1'b1;
      m_id = id;
    end else if (!in_seq) begin
      exp_err = 1'b1;
    end
    if (f || in_seq) begin
      n = l ? ((nb == 2'd0) ? 4 : int'(nb)) : 4;
      for (int j = 0; j < n; j++) mq.push_back(d[2*j +: 2]);
      if (l) begin
        if (mq.size() > TL) exp_err = 1'b1;
        in_seq = 1'b0;
      end
    end
    s_valid = 1'b1; s_data = d; s_first = f; s_last = l; s_nbases = nb; s_id = id;
    @(posedge clk); #1;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
  endtask

  task automatic chk_err(input string name);
    logic e;
`ifdef PACKER_ERR_EN
    e = exp_err;
`else
    e = 1'b0;
`endif
    chk(name, err, e);
  endtask

  // Called #1 after the edge that accepted the last beat; full holds for fc extra cycles.
  task automatic expect_load(input string name, input int fc);
    logic [OW-1:0] w = model_word();
    chk({name, "_pend_ld"}, ld, 0);
    chk({name, "_pend_rdy"}, s_ready, 0);
    chk({name, "_pend_word"}, feed_out, w);
    repeat (fc) begin
      @(posedge clk); #1;
      chk({name, "_hold_ld"}, ld, 0);
      chk({name, "_hold_rdy"}, s_ready, 0);
      chk({name, "_hold_word"}, feed_out, w);
    end
    full = 1'b0;
    @(posedge clk); #1;
    chk({name, "_ld"}, ld, 1);
    chk({name, "_word"}, feed_out, w);
    last_word = feed_out;
    @(posedge clk); #1;
    chk({name, "_ld_off"}, ld, 0);
    chk({name, "_rdy"}, s_ready, 1);
  endtask

  initial begin
    tbl[0] = '{48'hABC,          2, {8'h00, 8'h1B, 8'hE4}, 2'd2, 12'd6,  24'h000BE4};
    tbl[1] = '{48'h5,            1, {8'h00, 8'h00, 8'h03}, 2'd1, 12'd1,  24'h000003};
    tbl[2] = '{48'h123456789ABC, 3, {8'h56, 8'h34, 8'h12}, 2'd0, 12'd12, 24'h563412};
    tbl[3] = '{48'h7,            2, {8'h00, 8'hFF, 8'hFF}, 2'd3, 12'd7,  24'h003FFF};
    tbl[4] = '{48'hFFFFFFFFFFFF, 1, {8'h00, 8'h00, 8'hA5}, 2'd0, 12'd4,  24'h0000A5};

    // reset state
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", feed_out, 0);
    chk("rst_ld", ld, 0);
    chk("rst_rdy", s_ready, 1);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // table vectors, ld two cycles after the last beat
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < tbl[v].nbeats; b++)
        send(tbl[v].d[b], b == 0, b == tbl[v].nbeats - 1, tbl[v].nb, tbl[v].id);
      expect_load($sformatf("tbl%0d", v), 0);
      chk($sformatf("tbl%0d_const", v), last_word,
          mk_word(tbl[v].id, tbl[v].len, {{(2*TL-24){1'b0}}, tbl[v].tgt}));
    end
    chk_err("tbl_err");

    // backpressure: full high while the word is pending
    full = 1'b1;
    send(8'hE4, 1, 0, 2'd0, 48'hABC);
    send(8'h1B, 0, 1, 2'd2, 48'hABC);
    expect_load("full", 5);
    chk("full_const", last_word, mk_word(48'hABC, 12'd6, 256'hBE4));

    // 33 beats of all-ones: length clamps at TL, overflow bases dropped
    for (int b = 0; b < 33; b++) send(8'hFF, b == 0, b == 32, 2'd0, 48'h33);
    expect_load("long", 0);
    chk("long_const", last_word, mk_word(48'h33, 12'd128, {(2*TL){1'b1}}));
    chk_err("long_err");

    // restart on the third beat: only the second sequence survives
    send(8'h11, 1, 0, 2'd0, 48'h111);
    send(8'h22, 0, 0, 2'd0, 48'h111);
    send(8'h33, 1, 0, 2'd0, 48'h222);
    send(8'h44, 0, 1, 2'd0, 48'h222);
    expect_load("restart", 0);
    chk("restart_const", last_word, mk_word(48'h222, 12'd8, 256'h4433));
    chk_err("restart_err");

    // stray beat in IDLE is dropped
    send(8'h5A, 0, 1, 2'd0, 48'h999);
    chk("stray_ld", ld, 0);
    chk("stray_rdy", s_ready, 1);
    chk_err("stray_err");

    // reset while pending: word lost, no ld afterwards
    full = 1'b1;
    send(8'h03, 1, 1, 2'd1, 48'h77);
    chk("prst_rdy0", s_ready, 0);
    rst = 1'b0;
    #1;
    chk("prst_word", feed_out, 0);
    chk("prst_ld", ld, 0);
    chk("prst_err", err, 0);
    mq.delete(); in_seq = 1'b0; exp_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    full = 1'b0;
    chk("prst_rdy", s_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("prst_no_ld", ld, 0);
    end

    // randomized sequences against the queue model
    for (int r = 0; r < 60; r++) begin
      int nbeats, fc;
      logic [IW-1:0] id;
      if ($urandom_range(0, 7) == 0) send(8'($urandom), 0, 1'($urandom), 2'($urandom), '0);
      nbeats = $urandom_range(1, 40);
      id = {16'($urandom), 32'($urandom)};
      fc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      full = (fc > 0);
      for (int b = 0; b < nbeats; b++) begin
        logic f = (b == 0);
        if (b > 0 && $urandom_range(0, 15) == 0) begin
          f = 1'b1;
          id = {16'($urandom), 32'($urandom)};
        end
        send(8'($urandom), f, b == nbeats - 1, 2'($urandom), id);
      end
      expect_load($sformatf("rnd%0d", r), fc);
      chk_err($sformatf("rnd%0d_err", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
